io_ctrl: RTL and testbench

Memory-mapped I/O controller on the data side of the CPU, directly downstream of the MEM stage's `io_*` port. It decodes `io_addr` within the I/O region at `IO_START_MEM` = 0xFFFFFC00. It holds the LED and seven-segment registers and returns synchronized switch and debounced button state combinationally on `io_read_data`. It also scans an 8-digit multiplexed hex display.

---
 rtl/io_ctrl_pkg.sv | 49 ++++
 rtl/io_ctrl_seg7_scan.sv | 41 ++++
 rtl/io_ctrl.sv | 103 ++++++++++
 tb/tb_io_ctrl.sv | 176 +++++++++++++++++
 4 files changed

// File: rtl/io_ctrl_pkg.sv
// io_ctrl_pkg: I/O region addresses, register select type, address decode and hex font
package io_ctrl_pkg;
  localparam logic [31:0] IO_START_MEM  = 32'hFFFF_FC00;
  localparam logic [31:0] SEG_DATA_ADDR = 32'hFFFF_FC00;
  localparam logic [31:0] SEG_EN_ADDR   = 32'hFFFF_FC04;
  localparam logic [31:0] LED_ADDR      = 32'hFFFF_FC60;
  localparam logic [31:0] SW_ADDR       = 32'hFFFF_FC70;
  localparam logic [31:0] BTN_ADDR      = 32'hFFFF_FC74;
  localparam logic [31:0] ZERO_WORD     = 32'h0000_0000;
  typedef enum logic [2:0] {
    SEL_NONE,
    SEL_SEG_DATA,
    SEL_SEG_EN,
    SEL_LED,
    SEL_SW,
    SEL_BTN
  } io_sel_e;
  function automatic io_sel_e io_decode(input logic [31:0] addr);
    logic [31:0] a;
    a = {addr[31:2], 2'b00};
    return a == SEG_DATA_ADDR ? SEL_SEG_DATA :
           a == SEG_EN_ADDR   ? SEL_SEG_EN   :
           a == LED_ADDR      ? SEL_LED      :
           a == SW_ADDR       ? SEL_SW       :
           a == BTN_ADDR      ? SEL_BTN      : SEL_NONE;
  endfunction
  function automatic logic [6:0] hex_font(input logic [3:0] n);
    logic [6:0] f;
    case (n)
      4'h0: f = 7'h3F;
      4'h1: f = 7'h06;
      4'h2: f = 7'h5B;
      4'h3: f = 7'h4F;
      4'h4: f = 7'h66;
      4'h5: f = 7'h6D;
      4'h6: f = 7'h7D;
      4'h7: f = 7'h07;
      4'h8: f = 7'h7F;
      4'h9: f = 7'h6F;
      4'hA: f = 7'h77;
      4'hB: f = 7'h7C;
      4'hC: f = 7'h39;
      4'hD: f = 7'h5E;
      4'hE: f = 7'h79;
      default: f = 7'h71;
    endcase
    return f;
  endfunction
endpackage

// File: rtl/io_ctrl_seg7_scan.sv
// seg7_scan: multiplexes eight hex digits onto an active-low seven-segment display
module seg7_scan
  import io_ctrl_pkg::*;
#(
  parameter int SCAN_DIV = 100000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] data,
  input  logic [7:0]  en,
  output logic [7:0]  seg_an,
  output logic [7:0]  seg_out
);
  localparam int CW = SCAN_DIV > 1 ? $clog2(SCAN_DIV) : 1;
  logic [CW-1:0] scan_cnt;
  logic [2:0]    digit;
  logic          wrap;
  logic          lit;
  logic [3:0]    nib;
  // scan timer wrap and the currently selected digit's enable and nibble
  always_comb begin
    wrap = scan_cnt == CW'(SCAN_DIV - 1);
    lit  = en[digit];
    nib  = data[{digit, 2'b00} +: 4];
  end
  // each digit stays lit for SCAN_DIV cycles, then the scan moves to the next
  always_ff @(posedge clk) begin
    if (rst) begin
      scan_cnt <= '0;
      digit    <= '0;
    end else begin
      scan_cnt <= wrap ? '0 : scan_cnt + 1'b1;
      digit    <= wrap ? digit + 3'd1 : digit;
    end
  end
  // disabled digits are fully blanked; dp is never driven
  always_comb begin
    seg_an  = lit ? ~(8'd1 << digit) : 8'hFF;
    seg_out = lit ? {1'b1, ~hex_font(nib)} : 8'hFF;
  end
endmodule

// File: rtl/io_ctrl.sv
// io_ctrl: memory-mapped LED, switch, button and seven-segment controller
module io_ctrl
  import io_ctrl_pkg::*;
#(
  parameter int SCAN_DIV   = 100000,
  parameter int DEB_CYCLES = 20
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] io_addr,
  input  logic [31:0] io_write_data,
  input  logic        io_we,
  output logic [31:0] io_read_data,
  input  logic [23:0] switch,
  input  logic        button,
  output logic [23:0] led,
  output logic [7:0]  seg_an,
  output logic [7:0]  seg_out
);
  localparam int DW = DEB_CYCLES > 1 ? $clog2(DEB_CYCLES) : 1;
  io_sel_e       sel;
  logic [31:0]   seg_data;
  logic [7:0]    seg_en;
  logic [23:0]   sw_s1;
  logic [23:0]   sw_q;
  logic          btn_s1;
  logic          btn_s2;
  logic          btn_level;
  logic          btn_level_d;
  logic          btn_flag;
  logic [DW-1:0] deb_cnt;
  logic          rise;
  logic          clr;
  // address decode, combinational load data and flag set/clear conditions
  always_comb begin
    sel          = io_decode(io_addr);
    io_read_data = sel == SEL_SEG_DATA ? seg_data :
                   sel == SEL_SEG_EN   ? {24'd0, seg_en} :
                   sel == SEL_LED      ? {8'd0, led} :
                   sel == SEL_SW       ? {8'd0, sw_q} :
                   sel == SEL_BTN      ? {30'd0, btn_level, btn_flag} : ZERO_WORD;
    rise         = btn_level & ~btn_level_d;
    clr          = sel == SEL_BTN && !io_we;
  end
  // writable registers take store data truncated to their width
  always_ff @(posedge clk) begin
    if (rst) begin
      seg_data <= '0;
      seg_en   <= '0;
      led      <= '0;
    end else if (io_we) begin
      if (sel == SEL_SEG_DATA) seg_data <= io_write_data;
      if (sel == SEL_SEG_EN) seg_en <= io_write_data[7:0];
      if (sel == SEL_LED) led <= io_write_data[23:0];
    end
  end
  // two-flop synchronizers for the asynchronous board inputs
  always_ff @(posedge clk) begin
    if (rst) begin
      sw_s1  <= '0;
      sw_q   <= '0;
      btn_s1 <= 1'b0;
      btn_s2 <= 1'b0;
    end else begin
      sw_s1  <= switch;
      sw_q   <= sw_s1;
      btn_s1 <= button;
      btn_s2 <= btn_s1;
    end
  end
  // level follows the synchronized button only after DEB_CYCLES differing samples
  always_ff @(posedge clk) begin
    if (rst) begin
      deb_cnt   <= '0;
      btn_level <= 1'b0;
    end else if (btn_s2 == btn_level) begin
      deb_cnt <= '0;
    end else if (deb_cnt == DW'(DEB_CYCLES - 1)) begin
      deb_cnt   <= '0;
      btn_level <= btn_s2;
    end else begin
      deb_cnt <= deb_cnt + 1'b1;
    end
  end
  // sticky press flag: set on a debounced rising edge, cleared by a BTN load, set wins
  always_ff @(posedge clk) begin
    if (rst) begin
      btn_level_d <= 1'b0;
      btn_flag    <= 1'b0;
    end else begin
      btn_level_d <= btn_level;
      btn_flag    <= rise ? 1'b1 : clr ? 1'b0 : btn_flag;
    end
  end
  seg7_scan #(.SCAN_DIV(SCAN_DIV)) u_scan (
    .clk    (clk),
    .rst    (rst),
    .data   (seg_data),
    .en     (seg_en),
    .seg_an (seg_an),
    .seg_out(seg_out)
  );
endmodule

// File: tb/tb_io_ctrl.sv
// tb_io_ctrl: directed self-checking bench for io_ctrl
module tb_io_ctrl;
  localparam logic [31:0] A_SEGD = 32'hFFFF_FC00;
  localparam logic [31:0] A_SEGE = 32'hFFFF_FC04;
  localparam logic [31:0] A_LED  = 32'hFFFF_FC60;
  localparam logic [31:0] A_SW   = 32'hFFFF_FC70;
  localparam logic [31:0] A_BTN  = 32'hFFFF_FC74;
  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [31:0] io_addr = '0;
  logic [31:0] io_write_data = '0;
  logic        io_we = 1'b0;
  logic [31:0] io_read_data;
  logic [23:0] switch = '0;
  logic        button = 1'b0;
  logic [23:0] led;
  logic [7:0]  seg_an;
  logic [7:0]  seg_out;
  int          n_vec = 0;
  int          n_err = 0;
  logic [6:0]  font [16] = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
                             7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71};
  logic [31:0] sd;
  logic [3:0]  nib;
  io_ctrl #(.SCAN_DIV(4), .DEB_CYCLES(4)) dut (
    .clk          (clk),
    .rst          (rst),
    .io_addr      (io_addr),
    .io_write_data(io_write_data),
    .io_we        (io_we),
    .io_read_data (io_read_data),
    .switch       (switch),
    .button       (button),
    .led          (led),
    .seg_an       (seg_an),
    .seg_out      (seg_out)
  );
  always #5 clk = ~clk;
  task automatic tick();
    @(posedge clk);
    #2;
  endtask
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask
  task automatic wr(input logic [31:0] a, input logic [31:0] d);
    io_addr = a;
    io_write_data = d;
    io_we = 1'b1;
    tick();
    io_we = 1'b0;
    io_addr = '0;
  endtask
  task automatic peek(input string tag, input logic [31:0] a, input logic [31:0] exp);
    io_addr = a;
    #1;
    chk(tag, io_read_data, exp);
    io_addr = '0;
  endtask
  initial begin
    repeat (3) tick();
    chk("rst_led", {8'd0, led}, 32'h0);
    chk("rst_an", {24'd0, seg_an}, 32'hFF);
    chk("rst_out", {24'd0, seg_out}, 32'hFF);
    rst = 1'b0;
    tick();
    peek("rst_segd", A_SEGD, 32'h0);
    peek("rst_btn", A_BTN, 32'h0);
    wr(A_LED, 32'h00AB_CDEF);
    chk("led_out", {8'd0, led}, 32'h00AB_CDEF);
    peek("led_rd", A_LED, 32'h00AB_CDEF);
    peek("unmapped_rd", 32'hFFFF_FC64, 32'h0);
    peek("led_rd_unaligned", 32'hFFFF_FC63, 32'h00AB_CDEF);
    wr(A_LED, 32'h12FE_DCBA);
    chk("led_trunc", {8'd0, led}, 32'h00FE_DCBA);
    wr(32'hFFFF_FC64, 32'hDEAD_BEEF);
    peek("unmapped_wr", 32'hFFFF_FC64, 32'h0);
    wr(A_SEGE, 32'hFFFF_FFA5);
    peek("sege_trunc", A_SEGE, 32'h0000_00A5);
    wr(A_SW, 32'hFFFF_FFFF);
    peek("sw_ro", A_SW, 32'h0);
    switch = 24'h5A5A5A;
    peek("sw_c1", A_SW, 32'h0);
    tick();
    peek("sw_c2", A_SW, 32'h0);
    tick();
    peek("sw_c3", A_SW, 32'h005A_5A5A);
    tick();
    peek("sw_c4", A_SW, 32'h005A_5A5A);
    sd = 32'h1234_5678;
    wr(A_SEGD, sd);
    wr(A_SEGE, 32'h0000_00FF);
    peek("segd_rd", A_SEGD, sd);
    for (int i = 0; i < 64 && seg_an !== 8'h7F; i++) tick();
    chk("wait_d7", {24'd0, seg_an}, 32'h7F);
    for (int i = 0; i < 8 && seg_an === 8'h7F; i++) tick();
    for (int d = 0; d < 9; d++) begin
      for (int c = 0; c < 4; c++) begin
        nib = sd[4*(d%8) +: 4];
        chk($sformatf("scan_an_d%0d_c%0d", d, c), {24'd0, seg_an}, {24'd0, ~(8'd1 << (d%8))});
        chk($sformatf("scan_out_d%0d_c%0d", d, c), {24'd0, seg_out}, {24'd0, 1'b1, ~font[nib]});
        tick();
      end
    end
    wr(A_SEGE, 32'h0000_00FE);
    for (int i = 0; i < 40 && dut.u_scan.digit !== 3'd0; i++) tick();
    chk("en_fe_d0", {24'd0, seg_an}, 32'hFF);
    chk("en_fe_out", {24'd0, seg_out}, 32'hFF);
    for (int i = 0; i < 40 && dut.u_scan.digit !== 3'd1; i++) tick();
    chk("en_fe_d1", {24'd0, seg_an}, 32'hFD);
    for (int p = 0; p < 3; p++) begin
      button = 1'b1;
      repeat (3) tick();
      button = 1'b0;
      repeat (3) tick();
    end
    repeat (8) tick();
    peek("bounce", A_BTN, 32'h0);
    button = 1'b1;
    repeat (5) tick();
    peek("press_e5", A_BTN, 32'h0);
    tick();
    peek("press_e6", A_BTN, 32'h2);
    tick();
    peek("press_e7", A_BTN, 32'h3);
    repeat (3) tick();
    io_addr = A_BTN;
    #1;
    chk("btn_load", io_read_data, 32'h3);
    tick();
    io_addr = '0;
    peek("btn_after_load", A_BTN, 32'h2);
    button = 1'b0;
    repeat (5) tick();
    peek("rel_e5", A_BTN, 32'h2);
    tick();
    peek("rel_e6", A_BTN, 32'h0);
    io_addr = A_BTN;
    button = 1'b1;
    repeat (6) tick();
    chk("coll_level", io_read_data, 32'h2);
    tick();
    chk("coll_set_wins", io_read_data, 32'h3);
    tick();
    chk("coll_cleared", io_read_data, 32'h2);
    io_addr = '0;
    button = 1'b0;
    repeat (8) tick();
    wr(A_LED, 32'h00FF_FFFF);
    wr(A_SEGE, 32'h0000_00FF);
    button = 1'b1;
    repeat (4) tick();
    for (int i = 0; i < 40 && dut.u_scan.digit === 3'd0; i++) tick();
    chk("pre_rst_digit_nz", {31'd0, dut.u_scan.digit != 3'd0}, 32'h1);
    rst = 1'b1;
    tick();
    chk("mid_rst_led", {8'd0, led}, 32'h0);
    chk("mid_rst_an", {24'd0, seg_an}, 32'hFF);
    chk("mid_rst_out", {24'd0, seg_out}, 32'hFF);
    chk("mid_rst_digit", {29'd0, dut.u_scan.digit}, 32'h0);
    chk("mid_rst_cnt", {30'd0, dut.u_scan.scan_cnt}, 32'h0);
    chk("mid_rst_deb", {30'd0, dut.deb_cnt}, 32'h0);
    peek("mid_rst_sw", A_SW, 32'h0);
    peek("mid_rst_btn", A_BTN, 32'h0);
    peek("mid_rst_segd", A_SEGD, 32'h0);
    rst = 1'b0;
    button = 1'b0;
    tick();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
